fetch_decode_arbiter: RTL and testbench

FETCH_DECODE_ARBITER -- requirements
Module: fetch_decode_arbiter

---
 rtl/fetch_decode_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_fetch_decode_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_decode_arbiter
//
// Merges two fetch-entry streams into one registered output slot that feeds
// the decode stage.
//   * Port 0 is the primary fetch stream.
//   * Port 1 is the replay/debug stream. It may send multi-beat bursts, which
//     are kept together: once a burst starts, only port 1 is served until its
//     last beat.
//   * Outside a burst, port 1 normally wins. Port 0 is protected against
//     starvation: after StarveLimit consecutive port-1 grants while port 0 was
//     waiting, port 0 is served next.
//
// Parameters
//   DataWidth   : width of one fetch-entry payload
//   StarveLimit : max consecutive port-1 grants while port 0 waits (1..15)
//
// Ports
//   clk_i       in   clock; all state changes on the rising edge
//   rst_ni      in   asynchronous active-low reset
//   flush_i     in   synchronous pipeline flush (drops the output slot,
//                    aborts any burst, clears the starvation counter)
//   p0_data_i   in   port 0 payload
//   p0_valid_i  in   port 0 request
//   p0_ready_o  out  port 0 entry accepted this cycle
//   p1_data_i   in   port 1 payload
//   p1_valid_i  in   port 1 request
//   p1_last_i   in   final beat of a port-1 burst
//   p1_ready_o  out  port 1 entry accepted this cycle
//   data_o      out  registered payload toward decode
//   valid_o     out  data_o holds a valid entry
//   src_o       out  source of data_o (0 = port 0, 1 = port 1)
//   ack_i       in   consumer sampled data_o this cycle
// -----------------------------------------------------------------------------
module fetch_decode_arbiter #(
    parameter int DataWidth   = 64,
    parameter int StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] p0_data_i,
    input  logic                 p0_valid_i,
    output logic                 p0_ready_o,
    input  logic [DataWidth-1:0] p1_data_i,
    input  logic                 p1_valid_i,
    input  logic                 p1_last_i,
    output logic                 p1_ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic                 src_o,
    input  logic                 ack_i
);

    // Counter wide enough to hold the value StarveLimit itself.
    localparam int                CntWidth = $clog2(StarveLimit + 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(StarveLimit);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    typedef enum logic {
        IDLE  = 1'b0,   // normal arbitration between both ports
        LOCK1 = 1'b1    // inside a port-1 burst; port 0 is locked out
    } state_e;

    state_e                 state_reg, state_next;
    logic [CntWidth-1:0]    starve_cnt_reg, starve_cnt_next;
    logic                   valid_reg, valid_next;
    logic [DataWidth-1:0]   data_reg, data_next;
    logic                   src_reg, src_next;

    logic                   space;
    logic                   grant0;
    logic                   grant1;
    logic                   starved;
    logic [DataWidth-1:0]   data_sel;

    // The slot can take a new entry if it is empty or being drained now.
    assign space   = !valid_reg || ack_i;
    assign starved = (starve_cnt_reg == CntMax);

    // -------------------------------------------------------------------------
    // Arbitration and burst-lock FSM (next-state / grant logic)
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant0     = 1'b0;
        grant1     = 1'b0;

        // No grant while flushing or while the output slot is blocked.
        if (space && !flush_i) begin
            case (state_reg)
                IDLE: begin
                    if (p0_valid_i && starved) begin
                        grant0 = 1'b1;
                    end else if (p1_valid_i) begin
                        grant1 = 1'b1;
                    end else if (p0_valid_i) begin
                        grant0 = 1'b1;
                    end
                end
                LOCK1: begin
                    // Mid-burst: port 0 is ignored even when starved so the
                    // burst reaches decode without interleaving.
                    grant1 = p1_valid_i;
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end

        // A port-1 beat opens or closes a burst depending on its last flag.
        if (grant1) begin
            state_next = p1_last_i ? IDLE : LOCK1;
        end

        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter: consecutive port-1 wins while port 0 is waiting.
    // Any cycle where port 0 stops requesting, or gets served, restarts it.
    // A blocked cycle (no grant while port 0 waits) leaves it unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (flush_i || !p0_valid_i || grant0) begin
            starve_cnt_next = '0;
        end else if (grant1 && !starved) begin
            starve_cnt_next = starve_cnt_reg + CntOne;
        end
    end

    // -------------------------------------------------------------------------
    // Payload select, one mux per bit.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DataWidth; gi++) begin : gen_data_mux
            assign data_sel[gi] = grant1 ? p1_data_i[gi] : p0_data_i[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output slot next-state. data/src only change on a load, so the consumer
    // still sees the last entry (with valid low) after it has been drained or
    // flushed.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        src_next   = src_reg;
        if (flush_i) begin
            valid_next = 1'b0;
        end else if (grant0 || grant1) begin
            valid_next = 1'b1;
            data_next  = data_sel;
            src_next   = grant1;
        end else if (ack_i) begin
            valid_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            src_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            valid_reg      <= valid_next;
            data_reg       <= data_next;
            src_reg        <= src_next;
        end
    end

    // While reset is held the slot reads as empty, so the grant logic would
    // otherwise report ready; gate it so nothing is accepted during reset.
    assign p0_ready_o = grant0 && rst_ni;
    assign p1_ready_o = grant1 && rst_ni;

    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign src_o   = src_reg;

endmodule

// File: tb/tb_fetch_decode_arbiter.sv
module tb_fetch_decode_arbiter;

    localparam int DW     = 64;
    localparam int STARVE = 4;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_valid, p1_valid, p1_last;
    logic          p0_ready, p1_ready;
    logic [DW-1:0] data_out;
    logic          valid_out, src_out;
    logic          ack;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_arbiter #(.DataWidth(DW), .StarveLimit(STARVE)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .p0_data_i  (p0_data),
        .p0_valid_i (p0_valid),
        .p0_ready_o (p0_ready),
        .p1_data_i  (p1_data),
        .p1_valid_i (p1_valid),
        .p1_last_i  (p1_last),
        .p1_ready_o (p1_ready),
        .data_o     (data_out),
        .valid_o    (valid_out),
        .src_o      (src_out),
        .ack_i      (ack)
    );

    always #5 clk = ~clk;

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The slot is a single-entry buffer; "in_burst" means port 1 has sent a
    // non-final beat; "p1_streak" counts port-1 wins seen by a waiting port 0.
    bit          m_valid;
    logic [DW-1:0] m_data;
    bit          m_src;
    bit          m_in_burst;
    int          m_p1_streak;
    bit          e_g0, e_g1;
    bit          dut_src_log[$];   // sources of grants observed on the DUT

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_src = 0; m_in_burst = 0; m_p1_streak = 0;
    endtask

    task automatic model_grant();
        bit room;
        room = !m_valid || ack;
        e_g0 = 0; e_g1 = 0;
        if (room && !flush) begin
            if (m_in_burst)                                e_g1 = p1_valid;
            else if (p0_valid && m_p1_streak >= STARVE)    e_g0 = 1;
            else if (p1_valid)                             e_g1 = 1;
            else if (p0_valid)                             e_g0 = 1;
        end
    endtask

    task automatic model_commit();
        if (flush) begin
            m_valid = 0; m_in_burst = 0; m_p1_streak = 0;
            return;
        end
        if (e_g0) begin
            m_valid = 1; m_data = p0_data; m_src = 0;
        end else if (e_g1) begin
            m_valid = 1; m_data = p1_data; m_src = 1;
            m_in_burst = !p1_last;
        end else if (ack) begin
            m_valid = 0;
        end
        if (!p0_valid || e_g0)  m_p1_streak = 0;
        else if (e_g1)          m_p1_streak = (m_p1_streak + 1 > STARVE) ? STARVE : m_p1_streak + 1;
    endtask

    // One clock of model-checked traffic. Inputs must already be driven.
    task automatic step(input string tag);
        model_grant();
        @(negedge clk);
        chk1({tag, ".p0_ready"}, p0_ready, e_g0);
        chk1({tag, ".p1_ready"}, p1_ready, e_g1);
        if (p0_ready || p1_ready) dut_src_log.push_back(p1_ready);
        @(posedge clk);
        #1;
        model_commit();
        chk1 ({tag, ".valid"}, valid_out, m_valid);
        chk64({tag, ".data"},  data_out,  m_data);
        chk1 ({tag, ".src"},   src_out,   m_src);
    endtask

    task automatic idle_inputs();
        flush = 0; p0_valid = 0; p1_valid = 0; p1_last = 0; ack = 0;
        p0_data = '0; p1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("reset.valid", valid_out, 1'b0);
        chk64("reset.data",  data_out,  '0);
        chk1 ("reset.src",   src_out,   1'b0);
        rst_n = 1;
        model_reset();
        dut_src_log.delete();
    endtask

    task automatic both_valid(input logic last_beat, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        flush = 0; p0_valid = 1; p1_valid = 1; p1_last = last_beat; ack = 1;
        p0_data = d0; p1_data = d1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            flush, p0v, p1v, last, ack;
        logic [DW-1:0] p0d, p1d;
        bit            e_p0r, e_p1r, e_valid;
        logic [DW-1:0] e_data;
        bit            e_src;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // flush p0v p1v last ack  p0d  p1d    p0r p1r vld  data  src
        vecs[0]  = '{L, L, L, L, L, 64'h00, 64'h00, L, L, L, 64'h00, L};
        vecs[1]  = '{L, H, L, L, L, 64'h11, 64'h00, H, L, H, 64'h11, L};
        vecs[2]  = '{L, H, L, L, L, 64'h22, 64'h00, L, L, H, 64'h11, L}; // slot full
        vecs[3]  = '{L, H, L, L, H, 64'h22, 64'h00, H, L, H, 64'h22, L}; // ack frees it
        vecs[4]  = '{L, L, H, L, H, 64'h00, 64'hA1, L, H, H, 64'hA1, H}; // burst start
        vecs[5]  = '{L, H, H, L, H, 64'h33, 64'hA2, L, H, H, 64'hA2, H}; // locked
        vecs[6]  = '{L, H, L, L, H, 64'h33, 64'h00, L, L, L, 64'hA2, H}; // locked, p1 gap
        vecs[7]  = '{L, H, H, H, L, 64'h33, 64'hA3, L, H, H, 64'hA3, H}; // burst end
        vecs[8]  = '{L, H, H, H, H, 64'h33, 64'hA4, L, H, H, 64'hA4, H};
        vecs[9]  = '{L, H, H, H, H, 64'h33, 64'hA5, L, H, H, 64'hA5, H};
        vecs[10] = '{L, H, H, H, H, 64'h33, 64'hA6, H, L, H, 64'h33, L}; // starved p0
        vecs[11] = '{H, H, H, H, H, 64'h44, 64'hA7, L, L, L, 64'h33, L}; // flush
        vecs[12] = '{L, L, L, L, L, 64'h00, 64'h00, L, L, L, 64'h33, L};

        rst_n = 0;
        idle_inputs();
        do_reset();

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 13; i++) begin
            flush = vecs[i].flush; p0_valid = vecs[i].p0v; p1_valid = vecs[i].p1v;
            p1_last = vecs[i].last; ack = vecs[i].ack;
            p0_data = vecs[i].p0d; p1_data = vecs[i].p1d;
            @(negedge clk);
            chk1($sformatf("vec%0d.p0_ready", i), p0_ready, vecs[i].e_p0r);
            chk1($sformatf("vec%0d.p1_ready", i), p1_ready, vecs[i].e_p1r);
            @(posedge clk);
            #1;
            chk1 ($sformatf("vec%0d.valid", i), valid_out, vecs[i].e_valid);
            chk64($sformatf("vec%0d.data", i),  data_out,  vecs[i].e_data);
            chk1 ($sformatf("vec%0d.src", i),   src_out,   vecs[i].e_src);
        end

        // ---- fairness pattern: 4 port-1 wins then port 0 ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            both_valid(1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i));
            step("fair");
        end
        begin
            bit exp_fair[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
            chk_int("fair.grants", dut_src_log.size(), 10);
            for (int i = 0; i < 10 && i < dut_src_log.size(); i++)
                chk1($sformatf("fair.src%0d", i), dut_src_log[i], exp_fair[i]);
        end

        // ---- burst that crosses the starvation limit is not split ----
        do_reset();
        for (int i = 0; i < 3; i++) begin both_valid(1'b1, 64'h300, 64'h400 + 64'(i)); step("burst.pre"); end
        both_valid(1'b0, 64'h300, 64'h410); step("burst.b1");
        both_valid(1'b0, 64'h300, 64'h411); step("burst.b2");
        both_valid(1'b1, 64'h300, 64'h412); step("burst.b3");
        both_valid(1'b1, 64'h300, 64'h413); step("burst.after");
        begin
            bit exp_burst[7] = '{1, 1, 1, 1, 1, 1, 0};
            chk_int("burst.grants", dut_src_log.size(), 7);
            for (int i = 0; i < 7 && i < dut_src_log.size(); i++)
                chk1($sformatf("burst.src%0d", i), dut_src_log[i], exp_burst[i]);
        end
        chk64("burst.final_data", data_out, 64'h300);

        // ---- back-pressure: full slot holds, ack releases same cycle ----
        do_reset();
        p0_valid = 1; p0_data = 64'hAA; ack = 0; step("bp.load");
        p0_data = 64'hBB; step("bp.hold");
        chk64("bp.hold_data", data_out, 64'hAA);
        ack = 1; step("bp.release");
        chk64("bp.new_data", data_out, 64'hBB);

        // ---- flush inside a burst clears lock and starvation count ----
        do_reset();
        both_valid(1'b1, 64'h500, 64'h600); step("fl.w1");
        both_valid(1'b1, 64'h500, 64'h601); step("fl.w2");
        both_valid(1'b0, 64'h500, 64'h602); step("fl.lock");
        both_valid(1'b0, 64'h500, 64'h603); flush = 1; step("fl.flush");
        chk1("fl.valid_cleared", valid_out, 1'b0);
        dut_src_log.delete();
        for (int i = 0; i < 5; i++) begin both_valid(1'b1, 64'h510, 64'h610 + 64'(i)); step("fl.post"); end
        begin
            bit exp_fl[5] = '{1, 1, 1, 1, 0};
            chk_int("fl.grants", dut_src_log.size(), 5);
            for (int i = 0; i < 5 && i < dut_src_log.size(); i++)
                chk1($sformatf("fl.src%0d", i), dut_src_log[i], exp_fl[i]);
        end
        // Lock again, flush, then only port 0 asks: served only if back in IDLE.
        both_valid(1'b0, 64'h520, 64'h620); p0_valid = 0; step("fl2.lock");
        both_valid(1'b0, 64'h520, 64'h621); flush = 1; step("fl2.flush");
        idle_inputs(); p0_valid = 1; p0_data = 64'h521; step("fl2.p0");
        chk1("fl2.p0_served", src_out == 1'b0 && valid_out == 1'b1, 1'b1);

        // ---- asynchronous reset during a burst ----
        do_reset();
        idle_inputs(); p1_valid = 1; p1_last = 0; p1_data = 64'h700; ack = 1; step("ar.lock");
        p0_valid = 1; p0_data = 64'h701; p1_data = 64'h702;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk1 ("ar.valid",    valid_out, 1'b0);
        chk64("ar.data",     data_out,  '0);
        chk1 ("ar.src",      src_out,   1'b0);
        chk1 ("ar.p0_ready", p0_ready,  1'b0);
        chk1 ("ar.p1_ready", p1_ready,  1'b0);
        idle_inputs();
        #1 rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        p0_valid = 1; p0_data = 64'h703; step("ar.first");
        chk1 ("ar.first_src", src_out, 1'b0);
        chk64("ar.first_data", data_out, 64'h703);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            flush    = ($urandom_range(0, 24) == 0);
            p0_valid = ($urandom_range(0, 3) != 0);
            p1_valid = ($urandom_range(0, 2) != 0);
            p1_last  = ($urandom_range(0, 1) == 1);
            ack      = ($urandom_range(0, 3) != 0);
            p0_data  = {$urandom, $urandom};
            p1_data  = {$urandom, $urandom};
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
